// File: rtl/strip_id_allocator.sv
// strip_id_allocator: grants the first free ROM candidate strip for a height request and tracks occupancy.
// Optional statistics counters are built when STRIP_SEL_STATS_EN is defined.
module strip_id_allocator (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [4:0]  req_height,
    output logic        req_ready,
    output logic        rom_en,
    output logic [3:0]  rom_addr,
    input  logic [3:0]  rom_id1,
    input  logic [3:0]  rom_id2,
    input  logic [3:0]  rom_id3,
    output logic        grant_valid,
    output logic        grant_fail,
    output logic [3:0]  grant_id,
    input  logic        rel_valid,
    input  logic [3:0]  rel_id,
    output logic [15:0] occupancy,
    output logic [7:0]  grant_count,
    output logic [7:0]  fail_count
);
    typedef enum logic [1:0] {IDLE, LOOK, SCAN} state_t;
    state_t      state;
    logic [1:0]  k;
    logic        bad;
    logic        in_range;
    logic [4:0]  hm4;
    logic [3:0]  addr_n;
    logic [3:0]  cand;
    logic        eval;
    logic        hit;
    logic        done;
    logic [15:0] grant_mask;
    logic [15:0] rel_mask;
    always_comb begin
        in_range   = req_height >= 5'd4 && req_height <= 5'd16;
        hm4        = req_height - 5'd4;
        addr_n     = req_height > 5'd12 ? 4'd9 : hm4[3:0];
        cand       = k == 2'd0 ? rom_id1 : k == 2'd1 ? rom_id2 : rom_id3;
        // rom_en still high means the ROM output is not yet valid
        eval       = state == SCAN && !rom_en;
        hit        = eval && cand != 4'd0 && !occupancy[cand];
        done       = eval && (hit || k == 2'd2);
        grant_mask = hit ? 16'd1 << cand : 16'd0;
        rel_mask   = rel_valid ? 16'd1 << rel_id : 16'd0;
        req_ready  = state == IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= 2'd0;
            bad         <= 1'b0;
            rom_en      <= 1'b0;
            rom_addr    <= 4'd0;
            grant_valid <= 1'b0;
            grant_fail  <= 1'b0;
            grant_id    <= 4'd0;
            occupancy   <= 16'd0;
        end else begin
            grant_valid <= bad | done;
            grant_fail  <= bad | (done & ~hit);
            grant_id    <= hit ? cand : 4'd0;
            bad         <= 1'b0;
            occupancy   <= (occupancy | grant_mask) & ~rel_mask & 16'hFFFE;
            if (state == IDLE) begin
                if (req_valid && in_range) begin
                    rom_addr <= addr_n;
                    state    <= LOOK;
                end else if (req_valid) begin
                    bad <= 1'b1;
                end
            end else if (state == LOOK) begin
                rom_en <= 1'b1;
                k      <= 2'd0;
                state  <= SCAN;
            end else if (rom_en) begin
                rom_en <= 1'b0;
            end else if (done) begin
                rom_addr <= 4'd0;
                state    <= IDLE;
            end else begin
                k <= k + 2'd1;
            end
        end
    end
`ifdef STRIP_SEL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count <= 8'd0;
            fail_count  <= 8'd0;
        end else begin
            if (hit && grant_count != 8'hFF) grant_count <= grant_count + 8'd1;
            if ((bad || (done && !hit)) && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        end
    end
`else
    assign grant_count = 8'd0;
    assign fail_count  = 8'd0;
`endif
endmodule
